alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 8-bit ALU datapath.
- Accepts 8-bit instructions over a valid/ready handshake and holds a 4 x 8-bit register file.
- Drives the ALU operand and select ports, captures the ALU result, and writes it back or emits it on a result port.
- Sits between the instruction source (program ROM or test stimulus) and the external combinational ALU instance.

---
 rtl/alu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for an external combinational 8-bit ALU.
//
// Accepts 8-bit instructions over a valid/ready handshake, keeps a 4 x 8-bit
// register file, drives the ALU operand/select ports from the registered
// instruction, captures the ALU result and either writes it back to the
// register file or emits it on the result port.
//
// Instruction word: [7:6] opcode, [5:4] rd, [3:2] rs, [1:0] rt / unary func.
//   00 ADD   : R[rd] = R[rs] + R[rt]
//   01 UNARY : R[rd] = f(R[rs]), f selected by func (pass, +1, -2, -1)
//   10 LDI   : R[rd] = {4'b0000, imm4}
//   11 OUT   : result = R[rs] (register file and zero flag untouched)
//
// Ports:
//   i_clk            system clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset, overrides everything
//   i_instr          instruction word, sampled only on a handshake edge
//   i_instr_valid    i_instr holds a valid word
//   o_instr_ready    sequencer is idle and can accept an instruction
//   o_alu_src        0: two-operand add, 1: unary op selected by o_alu_in3
//   o_alu_op         high while the ALU result is being used (EXEC)
//   o_alu_in1        first ALU operand
//   o_alu_in2        second ALU operand
//   o_alu_in3        unary operation select
//   i_alu_out        combinational ALU result
//   o_result         last value emitted by an OUT instruction
//   o_result_valid   one-cycle pulse when o_result updates
//   o_zero           last register-file write was 8'h00
//
// Build option: define ALU_SEQ_FAST_EN to drop the WB state. Writeback then
// happens directly from i_alu_out on the EXEC exit edge, giving a 2-cycle
// issue period instead of 3.

module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_instr,
  input  logic       i_instr_valid,
  output logic       o_instr_ready,
  output logic       o_alu_src,
  output logic       o_alu_op,
  output logic [7:0] o_alu_in1,
  output logic [7:0] o_alu_in2,
  output logic [1:0] o_alu_in3,
  input  logic [7:0] i_alu_out,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  output logic       o_zero
);

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpUnary = 2'b01;
  localparam logic [1:0] OpLdi   = 2'b10;
  localparam logic [1:0] OpOut   = 2'b11;

  localparam logic [1:0] FuncPass = 2'b00;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10
  } state_e;

  state_e     r_state;
  logic [7:0] r_ir;
  logic [7:0] r_regs [4];
  logic [7:0] r_result;
  logic       r_result_valid;
  logic       r_zero;

  logic [1:0] w_opc;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [1:0] w_rt;
  logic       w_wb_fire;
  logic [7:0] w_wb_data;

  assign w_opc = r_ir[7:6];
  assign w_rd  = r_ir[5:4];
  assign w_rs  = r_ir[3:2];
  assign w_rt  = r_ir[1:0];

`ifdef ALU_SEQ_FAST_EN
  // No WB state: the ALU result is committed straight from the ALU on the
  // edge that leaves EXEC.
  assign w_wb_fire = (r_state == StExec);
  assign w_wb_data = i_alu_out;
`else
  logic [7:0] r_wbdata;

  assign w_wb_fire = (r_state == StWb);
  assign w_wb_data = r_wbdata;
`endif

  assign o_instr_ready  = (r_state == StIdle);
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_zero         = r_zero;

  // ALU port decode. Only registered state feeds these, so there is no
  // combinational path from the instruction inputs to the ALU.
  always_comb begin
    o_alu_src = 1'b0;
    o_alu_op  = 1'b0;
    o_alu_in1 = 8'h00;
    o_alu_in2 = 8'h00;
    o_alu_in3 = 2'b00;
    if (r_state == StExec) begin
      o_alu_op = 1'b1;
      unique case (w_opc)
        OpAdd: begin
          o_alu_src = 1'b0;
          o_alu_in1 = r_regs[w_rs];
          o_alu_in2 = r_regs[w_rt];
        end
        OpUnary: begin
          o_alu_src = 1'b1;
          o_alu_in1 = r_regs[w_rs];
          o_alu_in3 = w_rt;
        end
        OpLdi: begin
          // Immediate goes through the ALU pass path so all writes share
          // the same result capture.
          o_alu_src = 1'b1;
          o_alu_in1 = {4'b0000, r_ir[3:0]};
          o_alu_in3 = FuncPass;
        end
        OpOut: begin
          o_alu_src = 1'b1;
          o_alu_in1 = r_regs[w_rs];
          o_alu_in3 = FuncPass;
        end
        default: begin
          o_alu_src = 1'b0;
        end
      endcase
    end
  end

  // Control FSM, register file and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_ir           <= 8'h00;
`ifndef ALU_SEQ_FAST_EN
      r_wbdata       <= 8'h00;
`endif
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
      r_zero         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (i_instr_valid) begin
            r_ir    <= i_instr;
            r_state <= StExec;
          end
        end
        StExec: begin
`ifdef ALU_SEQ_FAST_EN
          r_state <= StIdle;
`else
          r_wbdata <= i_alu_out;
          r_state  <= StWb;
`endif
        end
        StWb: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase

      // Commit: OUT updates only the result port, everything else writes
      // the register file and refreshes the zero flag.
      if (w_wb_fire) begin
        if (w_opc == OpOut) begin
          r_result       <= w_wb_data;
          r_result_valid <= 1'b1;
        end else begin
          r_regs[w_rd] <= w_wb_data;
          r_zero       <= (w_wb_data == 8'h00);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

`ifdef ALU_SEQ_FAST_EN
  localparam int WbLat = 1;
`else
  localparam int WbLat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       alu_src;
  logic       alu_op;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [1:0] alu_in3;
  logic [7:0] alu_out;
  logic [7:0] result;
  logic       result_valid;
  logic       zero;

  int checks = 0;
  int failures = 0;

  alu_sequencer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_instr        (instr),
    .i_instr_valid  (instr_valid),
    .o_instr_ready  (instr_ready),
    .o_alu_src      (alu_src),
    .o_alu_op       (alu_op),
    .o_alu_in1      (alu_in1),
    .o_alu_in2      (alu_in2),
    .o_alu_in3      (alu_in3),
    .i_alu_out      (alu_out),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_zero         (zero)
  );

  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    alu_out = 8'h00;
    if (!alu_src) begin
      alu_out = alu_in1 + alu_in2;
    end else begin
      case (alu_in3)
        2'b00:   alu_out = alu_in1;
        2'b01:   alu_out = alu_in1 + 8'd1;
        2'b10:   alu_out = alu_in1 - 8'd2;
        default: alu_out = alu_in1 - 8'd1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Starts and ends at a falling edge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Transfers one word, then advances to the cycle in which the commit is
  // visible. Starts and ends at a falling edge.
  task automatic issue(input logic [7:0] w);
    int waited;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("issue_ready", {7'd0, instr_ready}, 8'd1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_alu_op", {7'd0, alu_op}, 8'd1);
    chk("exec_alu_src", {7'd0, alu_src}, {7'd0, (w[7:6] != 2'b00)});
    repeat (WbLat) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst_before;
    logic [7:0] instr;
    bit         is_out;
    logic [7:0] exp_res;
    bit         exp_zero;
  } vec_t;

  function automatic vec_t mkv(bit r, logic [7:0] i, bit o, logic [7:0] e, bit z);
    vec_t v;
    v.rst_before = r;
    v.instr      = i;
    v.is_out     = o;
    v.exp_res    = e;
    v.exp_zero   = z;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [7:0] stream [4];
    int         xfer_cyc [4];
    int         idx;
    int         cyc;
    bit         rdy;

    // Program and wrap-around vectors.
    vecs.push_back(mkv(1, 8'h95, 0, 8'h00, 0));  // LDI R1,5
    vecs.push_back(mkv(0, 8'hA3, 0, 8'h00, 0));  // LDI R2,3
    vecs.push_back(mkv(0, 8'h36, 0, 8'h00, 0));  // R3 = R1+R2 = 8
    vecs.push_back(mkv(0, 8'hCC, 1, 8'h08, 0));  // OUT R3
    vecs.push_back(mkv(1, 8'h53, 0, 8'h00, 0));  // R1 = R0-1 = FF
    vecs.push_back(mkv(0, 8'h55, 0, 8'h00, 1));  // R1 = R1+1 = 00
    vecs.push_back(mkv(0, 8'hC4, 1, 8'h00, 1));  // OUT R1, zero kept
    vecs.push_back(mkv(0, 8'hA1, 0, 8'h00, 0));  // LDI R2,1
    vecs.push_back(mkv(0, 8'h6A, 0, 8'h00, 0));  // R2 = R2-2 = FF
    vecs.push_back(mkv(0, 8'hC8, 1, 8'hFF, 0));  // OUT R2
    vecs.push_back(mkv(0, 8'h3A, 0, 8'h00, 0));  // R3 = R2+R2 = FE
    vecs.push_back(mkv(0, 8'hCC, 1, 8'hFE, 0));  // OUT R3
    vecs.push_back(mkv(0, 8'h7C, 0, 8'h00, 0));  // R3 = pass R3 = FE
    vecs.push_back(mkv(0, 8'h4E, 0, 8'h00, 0));  // R0 = R3-2 = FC
    vecs.push_back(mkv(0, 8'hC0, 1, 8'hFC, 0));  // OUT R0
    vecs.push_back(mkv(0, 8'h80, 0, 8'h00, 1));  // LDI R0,0
    vecs.push_back(mkv(0, 8'h15, 0, 8'h00, 1));  // R1 = R1+R1 = 00
    vecs.push_back(mkv(0, 8'h5D, 0, 8'h00, 0));  // R1 = R3+1 = FF
    vecs.push_back(mkv(0, 8'hC4, 1, 8'hFF, 0));  // OUT R1

    // Reset state.
    @(negedge clk);
    do_reset(2);
    chk("rst_ready", {7'd0, instr_ready}, 8'd1);
    chk("rst_result", result, 8'h00);
    chk("rst_result_valid", {7'd0, result_valid}, 8'd0);
    chk("rst_zero", {7'd0, zero}, 8'd0);
    chk("rst_alu_op", {7'd0, alu_op}, 8'd0);
    chk("rst_alu_in1", alu_in1, 8'h00);
    chk("rst_alu_in2", alu_in2, 8'h00);
    chk("rst_alu_srcsel", {5'd0, alu_src, alu_in3}, 8'h00);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset(2);
      issue(vecs[i].instr);
      if (vecs[i].is_out) begin
        chk($sformatf("v%0d_result_valid", i), {7'd0, result_valid}, 8'd1);
        chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
        @(negedge clk);
        chk($sformatf("v%0d_rv_single", i), {7'd0, result_valid}, 8'd0);
      end else begin
        chk($sformatf("v%0d_no_rv", i), {7'd0, result_valid}, 8'd0);
      end
      chk($sformatf("v%0d_zero", i), {7'd0, zero}, {7'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_alu_idle", i), {7'd0, alu_op}, 8'd0);
      chk($sformatf("v%0d_in1_idle", i), alu_in1, 8'h00);
    end

    // Back-to-back stream with INSTR_VALID held high.
    do_reset(2);
    stream[0] = 8'h87;  // LDI R0,7
    stream[1] = 8'h53;  // R1 = R0-1 = 6
    stream[2] = 8'h14;  // R1 = R1+R0 = 0D
    stream[3] = 8'hC4;  // OUT R1
    foreach (xfer_cyc[i]) xfer_cyc[i] = 0;
    idx = 0;
    cyc = 0;
    instr_valid = 1'b1;
    while (idx < 4 && cyc < 40) begin
      instr = stream[idx];
      rdy = instr_ready;
      @(posedge clk);
      if (rdy) begin
        xfer_cyc[idx] = cyc;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stream_xfers", idx[7:0], 8'd4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("stream_period%0d", i), 8'(xfer_cyc[i] - xfer_cyc[i-1]), 8'(WbLat + 1));
    end
    repeat (WbLat) @(posedge clk);
    @(negedge clk);
    chk("stream_rv", {7'd0, result_valid}, 8'd1);
    chk("stream_result", result, 8'h0D);

    // Idle with no valid: nothing happens.
    instr = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ready%0d", i), {7'd0, instr_ready}, 8'd1);
      chk($sformatf("idle_alu_op%0d", i), {7'd0, alu_op}, 8'd0);
    end
    chk("idle_result", result, 8'h0D);
    chk("idle_rv", {7'd0, result_valid}, 8'd0);

    // Reset during EXEC discards the instruction.
    do_reset(2);
    instr = 8'h95;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_exec", {7'd0, alu_op}, 8'd1);
    rst = 1'b1;
    instr = 8'h8F;  // must be ignored while in reset
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("midrst_ready", {7'd0, instr_ready}, 8'd1);
    chk("midrst_rv0", {7'd0, result_valid}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_rv%0d", i + 1), {7'd0, result_valid}, 8'd0);
      chk($sformatf("midrst_op%0d", i + 1), {7'd0, alu_op}, 8'd0);
    end
    issue(8'hC4);
    chk("midrst_out_rv", {7'd0, result_valid}, 8'd1);
    chk("midrst_r1", result, 8'h00);
    chk("midrst_zero", {7'd0, zero}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
